// File: rtl/v_query_ctrl_pkg.sv
// Shared types for the query flow-control stage and its response FIFO.
package v_query_ctrl_pkg;

    typedef logic [7:0]  id_t;
    typedef logic [3:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] volume_t;
    typedef logic [7:0]  listsize_t;

    // One pipeline result as held in the response FIFO and returned to the host.
    typedef struct packed {
        key_t      key;
        volume_t   volume;
        logic      error;
        listsize_t listsize;
    } query_rsp_t;

    localparam int RESP_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/v_query_ctrl_if.sv
// Host command, pipeline lookup and host response signals of v_query_ctrl.
// The slave modport is the controller's view; master is the host/pipeline view.
interface v_query_ctrl_if;
    import v_query_ctrl_pkg::*;

    // host command channel
    logic      i_cmd_vld;
    id_t       i_cmd_prod_id;
    level_t    i_cmd_level;
    logic      o_cmd_rdy;

    // query pipeline S0 issue
    logic      o_lut_vld;
    id_t       o_lut_prod_id;
    level_t    o_lut_level;

    // query pipeline S1 result
    logic      i_lut_vld_r;
    key_t      i_lut_key;
    volume_t   i_lut_size;
    logic      i_lut_error;
    listsize_t i_lut_listsize;

    // host response channel
    logic      o_rsp_vld;
    key_t      o_rsp_key;
    volume_t   o_rsp_size;
    logic      o_rsp_error;
    listsize_t o_rsp_listsize;
    logic      i_rsp_rdy;

    // status
    logic      o_idle;
    logic      o_proto_err_r;

    modport slave (
        input  i_cmd_vld, i_cmd_prod_id, i_cmd_level,
        input  i_lut_vld_r, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
        input  i_rsp_rdy,
        output o_cmd_rdy,
        output o_lut_vld, o_lut_prod_id, o_lut_level,
        output o_rsp_vld, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize,
        output o_idle, o_proto_err_r
    );

    modport master (
        output i_cmd_vld, i_cmd_prod_id, i_cmd_level,
        output i_lut_vld_r, i_lut_key, i_lut_size, i_lut_error, i_lut_listsize,
        output i_rsp_rdy,
        input  o_cmd_rdy,
        input  o_lut_vld, o_lut_prod_id, o_lut_level,
        input  o_rsp_vld, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize,
        input  o_idle, o_proto_err_r
    );

endinterface

// File: rtl/v_query_rsp_fifo.sv
// In-order response FIFO. Pointers carry an extra wrap bit so full and empty
// are told apart by pointer compare alone. Output comes straight from the
// storage registers at the head; a push is visible the cycle after it lands.
module v_query_rsp_fifo #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(N);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [N];
    logic         w_push_ok;
    logic         w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_vld     = ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Advance head/tail pointers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Write the pushed entry at the tail; storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/v_query_ctrl.sv
// Flow control around the query pipeline: issues host commands to S0, captures
// the S1 result one cycle later into the response FIFO and returns it to the
// host. Every issue consumes a credit that only a host pop gives back, so the
// non-stallable pipeline can never push into a full FIFO.
module v_query_ctrl
    import v_query_ctrl_pkg::*;
#(
    parameter int RESP_DEPTH = RESP_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    v_query_ctrl_if.slave bus
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [CW-1:0] r_credits;
    logic [CW-1:0] w_credits_next;
    logic          r_inflight;
    logic          r_proto_err;

    logic          w_cmd_rdy;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_vld;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    query_rsp_t    w_push_data;
    query_rsp_t    w_rsp_data;

    // Ready depends only on flops (and reset), never on the response side.
    assign w_cmd_rdy = rst_n & (r_credits != '0);
    assign w_issue   = bus.i_cmd_vld & w_cmd_rdy;

    // A result is only accepted in the cycle right after an issue.
    assign w_push    = bus.i_lut_vld_r & r_inflight;
    assign w_pop     = w_fifo_vld & bus.i_rsp_rdy;

    assign w_push_data = '{key:      bus.i_lut_key,
                           volume:   bus.i_lut_size,
                           error:    bus.i_lut_error,
                           listsize: bus.i_lut_listsize};

    assign bus.o_cmd_rdy      = w_cmd_rdy;
    assign bus.o_lut_vld      = w_issue;
    assign bus.o_lut_prod_id  = bus.i_cmd_prod_id;
    assign bus.o_lut_level    = bus.i_cmd_level;
    assign bus.o_rsp_vld      = w_fifo_vld;
    assign bus.o_rsp_key      = w_rsp_data.key;
    assign bus.o_rsp_size     = w_rsp_data.volume;
    assign bus.o_rsp_error    = w_rsp_data.error;
    assign bus.o_rsp_listsize = w_rsp_data.listsize;
    assign bus.o_idle         = (r_credits == CW'(RESP_DEPTH));
    assign bus.o_proto_err_r  = r_proto_err;

    // Credit update: issue takes one, pop returns one, both together cancel.
    always_comb begin
        w_credits_next = r_credits;
        if (w_issue && !w_pop) begin
            w_credits_next = r_credits - CW'(1);
        end else if (!w_issue && w_pop) begin
            w_credits_next = r_credits + CW'(1);
        end
    end

    // Credits, in-flight marker and sticky protocol error; a missing result
    // keeps its credit consumed, a stray one is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits   <= CW'(RESP_DEPTH);
            r_inflight  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_credits  <= w_credits_next;
            r_inflight <= w_issue;
            if (bus.i_lut_vld_r != r_inflight) r_proto_err <= 1'b1;
        end
    end

    v_query_rsp_fifo #(
        .N (RESP_DEPTH),
        .W ($bits(query_rsp_t))
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_vld       (w_fifo_vld),
        .o_data      (w_rsp_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // The credit scheme guarantees a free slot for every accepted result.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));

    // With every credit at home nothing can be waiting in the FIFO.
    a_idle_means_empty: assert property (
        @(posedge clk) disable iff (!rst_n) bus.o_idle |-> w_fifo_empty);

endmodule
